// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit ends of the PC link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS       = 8;
  localparam int   FRAME_BITS      = 10;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: serial line in, byte/status out, read acknowledge.
interface uart_receiver_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 read;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_error;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx,
    input  read,
    output data_out,
    output data_valid,
    output frame_error,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output read,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle level
// so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);
  import uart_pkg::*;

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling via a divider counter, byte presented
// with a valid/read handshake plus sticky framing-error and overrun flags.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | half-bit wait, confirm start bit still low
// DATA      | sample DATA_BITS bits, LSB first
// STOP      | sample stop bit, deliver byte or flag framing error
// WAIT_HIGH | line held low after bad stop, wait for it to return high
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic            clock_i,
  input  logic            reset_ni,
  uart_receiver_if.master bus
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 fe_q;
  logic                 ovr_q;
  logic                 busy_q;

  uart_rx_sync u_sync (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .async_i (bus.rx),
    .sync_o  (rx_s)
  );

  // Frame completion is written after the read clear so a byte landing on the
  // read cycle keeps data_valid set.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (bus.read) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rx_s != UART_IDLE_LEVEL) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == HALF_LIM) begin
            cnt_q <= '0;
            if (rx_s != UART_IDLE_LEVEL) begin
              state_q <= DATA;
              bit_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == FULL_LIM) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == FULL_LIM) begin
            cnt_q <= '0;
            if (rx_s == UART_IDLE_LEVEL) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              fe_q    <= 1'b0;
              ovr_q   <= valid_q & ~bus.read;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              fe_q    <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        WAIT_HIGH: begin
          if (rx_s == UART_IDLE_LEVEL) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_error = fe_q;
  assign bus.overrun     = ovr_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// frames and reads against a frame-level reference model.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  uart_receiver_if bus_if ();

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .bus      (bus_if.master)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  // Reference model: what the consumer must see, driven by frame completions.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       old_v;
  bit         pend_valid = 1'b0;
  int         pend_edge  = 0;
  logic [7:0] pend_byte  = 8'h00;
  bit         pend_ok    = 1'b0;
  int         mask_lo    = -10;
  int         mask_hi    = -10;

  int   rise_cyc   = -1;
  int   fall_cyc   = -1;
  bit   busy_seen  = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_busy  = 1'b0;
  bit   rand_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_data     = 8'h00;
      m_valid    = 1'b0;
      m_fe       = 1'b0;
      m_ovr      = 1'b0;
      pend_valid = 1'b0;
    end else begin
      old_v = m_valid;
      if (bus_if.read) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if (pend_valid && cyc == pend_edge) begin
        pend_valid = 1'b0;
        if (pend_ok) begin
          m_data  = pend_byte;
          m_ovr   = old_v && !bus_if.read;
          m_valid = 1'b1;
          m_fe    = 1'b0;
        end else begin
          m_fe = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare; the +/-1 synchroniser-phase window around a completion is skipped.
  always @(negedge clk) begin
    if (rst_n && !(cyc >= mask_lo && cyc <= mask_hi))
      check("outputs", {bus_if.data_out, bus_if.data_valid, bus_if.frame_error, bus_if.overrun},
            {m_data, m_valid, m_fe, m_ovr});
    if (bus_if.data_valid && !prev_valid) rise_cyc = cyc;
    if (!bus_if.busy && prev_busy) fall_cyc = cyc;
    if (bus_if.busy) busy_seen = 1'b1;
    prev_valid = bus_if.data_valid;
    prev_busy  = bus_if.busy;
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Leaves rx low after a bad stop bit; the caller decides when the line recovers.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
    bus_if.rx  = 1'b0;
    pend_byte  = b;
    pend_ok    = stop_ok;
    pend_edge  = cyc + LAT;
    pend_valid = 1'b1;
    mask_lo    = pend_edge - 1;
    mask_hi    = pend_edge + 1;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus_if.rx = b[i];
      tick(CPB);
    end
    bus_if.rx = stop_ok;
    tick(CPB);
    if (!stop_ok) tick(hold_low);
  endtask

  task automatic do_read();
    bus_if.read = 1'b1;
    tick(1);
    bus_if.read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout at cycle %0d, required finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int guard;
    bus_if.rx   = 1'b1;
    bus_if.read = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    check("rst_data", bus_if.data_out, 8'h00);
    check("rst_valid", bus_if.data_valid, 1'b0);
    check("rst_fe", bus_if.frame_error, 1'b0);
    check("rst_ovr", bus_if.overrun, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // 0x55 with latency measurement
    rise_cyc = -1;
    fall_cyc = -1;
    c0 = cyc;
    send_frame(8'h55, 1'b1, 0);
    tick(4);
    check("t1_latency_window", (rise_cyc - c0 >= LAT - 1) && (rise_cyc - c0 <= LAT + 1), 1'b1);
    check("t1_busy_fall", fall_cyc, rise_cyc);
    check("t1_data", bus_if.data_out, 8'h55);
    check("t1_valid", bus_if.data_valid, 1'b1);
    check("t1_fe", bus_if.frame_error, 1'b0);
    check("t1_busy", bus_if.busy, 1'b0);
    do_read();
    check("t1_read_clear", bus_if.data_valid, 1'b0);
    tick(3);

    // short low glitch
    busy_seen = 1'b0;
    bus_if.rx = 1'b0;
    tick(4);
    bus_if.rx = 1'b1;
    tick(30);
    check("t2_busy_pulsed", busy_seen, 1'b1);
    check("t2_busy", bus_if.busy, 1'b0);
    check("t2_valid", bus_if.data_valid, 1'b0);
    check("t2_fe", bus_if.frame_error, 1'b0);
    check("t2_ovr", bus_if.overrun, 1'b0);

    // bad stop bit, line held low, then recovery
    send_frame(8'hA5, 1'b0, 40);
    check("t3_fe", bus_if.frame_error, 1'b1);
    check("t3_valid", bus_if.data_valid, 1'b0);
    check("t3_busy_low", bus_if.busy, 1'b1);
    bus_if.rx = 1'b1;
    tick(6);
    check("t3_busy_released", bus_if.busy, 1'b0);
    tick(4);
    send_frame(8'h3C, 1'b1, 0);
    tick(2);
    check("t3_data", bus_if.data_out, 8'h3C);
    check("t3_valid2", bus_if.data_valid, 1'b1);
    check("t3_fe_cleared", bus_if.frame_error, 1'b0);
    do_read();
    tick(3);

    // overrun
    send_frame(8'h01, 1'b1, 0);
    tick(3);
    send_frame(8'h02, 1'b1, 0);
    tick(2);
    check("t4_data", bus_if.data_out, 8'h02);
    check("t4_ovr", bus_if.overrun, 1'b1);
    check("t4_valid", bus_if.data_valid, 1'b1);
    do_read();
    check("t4_valid_clr", bus_if.data_valid, 1'b0);
    check("t4_ovr_clr", bus_if.overrun, 1'b0);
    tick(3);

    // read on the completion cycle
    send_frame(8'h01, 1'b1, 0);
    tick(3);
    guard = 0;
    fork
      send_frame(8'h7E, 1'b1, 0);
      begin
        tick(1);
        while (cyc != pend_edge - 1 && guard < 400) begin
          tick(1);
          guard++;
        end
        check("t5_read_align", guard < 400, 1'b1);
        do_read();
      end
    join
    tick(2);
    check("t5_data", bus_if.data_out, 8'h7E);
    check("t5_valid", bus_if.data_valid, 1'b1);
    check("t5_ovr", bus_if.overrun, 1'b0);
    do_read();
    tick(3);

    // reset during data bit 4, then a clean frame
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        tick(CPB + 4 * CPB + CPB / 2);
        check("t6_busy_before", bus_if.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data", bus_if.data_out, 8'h00);
        check("t6_rst_valid", bus_if.data_valid, 1'b0);
        check("t6_rst_fe", bus_if.frame_error, 1'b0);
        check("t6_rst_ovr", bus_if.overrun, 1'b0);
        check("t6_rst_busy", bus_if.busy, 1'b0);
        tick(10);
        rst_n = 1'b1;
      end
    join
    tick(4);
    send_frame(8'hF0, 1'b1, 0);
    tick(2);
    check("t6_data", bus_if.data_out, 8'hF0);
    check("t6_valid", bus_if.data_valid, 1'b1);
    check("t6_fe", bus_if.frame_error, 1'b0);
    check("t6_ovr", bus_if.overrun, 1'b0);
    tick(3);

    // randomized frames with concurrent random reads
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          logic [7:0] b;
          bit ok;
          b  = 8'($urandom_range(0, 255));
          ok = ($urandom_range(0, 5) != 0);
          send_frame(b, ok, ok ? 0 : int'($urandom_range(0, 20)));
          bus_if.rx = 1'b1;
          tick(int'($urandom_range(4, 20)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus_if.read = ($urandom_range(0, 24) == 0);
          tick(1);
        end
        bus_if.read = 1'b0;
      end
    join
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
